adder_axi_sequencer: RTL and testbench

// AXI4-Lite master that drives the memory-mapped adder slave on behalf of two requesters.

---
 rtl/adder_axi_sequencer_if.sv | 35 +++
 rtl/adder_axi_sequencer.sv | 155 +++++++++++++++
 tb/tb_adder_axi_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adder_axi_sequencer_if.sv
// AXI4-Lite bus between the adder sequencer (master) and the adder register slave.
// Latency: none, wires only.
// Backpressure: every channel uses a valid/ready pair; the receiver stalls the sender by holding ready low.
interface adder_axi_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic                    bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/adder_axi_sequencer.sv
// Arbitrates two operand requesters and runs write A, write B, read sum, read status on the adder slave.
// Latency: variable, one cycle per AXI beat minimum plus slave stalls; one transaction in flight.
// Backpressure: requesters wait for a one-cycle ready pulse; the result is held until rsp_ready.
module adder_axi_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int OPA_ADDR   = 0,
    parameter int OPB_ADDR   = 4,
    parameter int SUM_ADDR   = 24,
    parameter int STAT_ADDR  = 28
) (
    input  logic                  m1_axi_aclk,
    input  logic                  m1_axi_areset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_id,
    output logic [DATA_WIDTH-1:0] rsp_sum,
    output logic [DATA_WIDTH-1:0] rsp_stat,
    output logic                  rsp_err,
    output logic                  busy,
    adder_axi_sequencer_if.master m1_axi
);
    typedef enum logic [3:0] {
        IDLE, WR_A, WB_A, WR_B, WB_B, RD_S, RR_S, RD_T, RR_T, RSP
    } state_t;

    state_t                state, state_nxt;
    logic                  last;        // requester granted most recently
    logic                  aw_done;     // AW beat of the current write already accepted
    logic                  w_done;      // W beat of the current write already accepted
    logic                  grant;
    logic                  grant_id;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;

    // Next state, grant decision and all bus outputs, decoded from the current state.
    always_comb begin
        state_nxt      = state;
        grant          = 1'b0;
        grant_id       = 1'b0;
        m1_axi.awaddr  = '0;
        m1_axi.awvalid = 1'b0;
        m1_axi.wdata   = '0;
        m1_axi.wstrb   = '1;
        m1_axi.wvalid  = 1'b0;
        m1_axi.bready  = 1'b0;
        m1_axi.araddr  = '0;
        m1_axi.arvalid = 1'b0;
        m1_axi.rready  = 1'b0;
        case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant     = 1'b1;
                    // Both pending: serve the one not served last time.
                    grant_id  = (req0_valid && req1_valid) ? ~last : ~req0_valid;
                    state_nxt = WR_A;
                end
            end
            WR_A, WR_B: begin
                m1_axi.awvalid = ~aw_done;
                m1_axi.wvalid  = ~w_done;
                m1_axi.awaddr  = (state == WR_A) ? ADDR_WIDTH'(OPA_ADDR) : ADDR_WIDTH'(OPB_ADDR);
                m1_axi.wdata   = (state == WR_A) ? a_q : b_q;
                // The two beats may complete in either order or together.
                if ((aw_done || m1_axi.awready) && (w_done || m1_axi.wready))
                    state_nxt = (state == WR_A) ? WB_A : WB_B;
            end
            WB_A, WB_B: begin
                m1_axi.bready = 1'b1;
                if (m1_axi.bvalid)
                    state_nxt = m1_axi.bresp ? RSP : ((state == WB_A) ? WR_B : RD_S);
            end
            RD_S, RD_T: begin
                m1_axi.arvalid = 1'b1;
                m1_axi.araddr  = (state == RD_S) ? ADDR_WIDTH'(SUM_ADDR) : ADDR_WIDTH'(STAT_ADDR);
                if (m1_axi.arready)
                    state_nxt = (state == RD_S) ? RR_S : RR_T;
            end
            RR_S, RR_T: begin
                m1_axi.rready = 1'b1;
                if (m1_axi.rvalid)
                    state_nxt = (m1_axi.rresp || state == RR_T) ? RSP : RD_T;
            end
            RSP: begin
                if (rsp_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Reset holds IDLE, so the grant must be masked while reset is asserted.
        req0_ready = grant & ~grant_id & ~m1_axi_areset;
        req1_ready = grant &  grant_id & ~m1_axi_areset;
        rsp_valid  = (state == RSP);
        busy       = (state != IDLE);
    end

    // State register.
    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Operand capture, beat bookkeeping, arbitration pointer and result registers.
    always_ff @(posedge m1_axi_aclk or posedge m1_axi_areset) begin
        if (m1_axi_areset) begin
            last     <= 1'b1;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            rsp_id   <= 1'b0;
            rsp_sum  <= '0;
            rsp_stat <= '0;
            rsp_err  <= 1'b0;
        end else begin
            // Done flags live only while a write phase lasts, so each valid drops after its own beat.
            aw_done <= (state == WR_A || state == WR_B) && (state_nxt == state) &&
                       (aw_done || m1_axi.awready);
            w_done  <= (state == WR_A || state == WR_B) && (state_nxt == state) &&
                       (w_done || m1_axi.wready);
            if (grant) begin
                a_q      <= grant_id ? req1_a : req0_a;
                b_q      <= grant_id ? req1_b : req0_b;
                rsp_id   <= grant_id;
                last     <= grant_id;
                rsp_sum  <= '0;
                rsp_stat <= '0;
                rsp_err  <= 1'b0;
            end
            if ((state == WB_A || state == WB_B) && m1_axi.bvalid && m1_axi.bresp)
                rsp_err <= 1'b1;
            if ((state == RR_S || state == RR_T) && m1_axi.rvalid) begin
                // An error response reports a zero sum and status.
                if (m1_axi.rresp) begin
                    rsp_err <= 1'b1;
                    rsp_sum <= '0;
                end else if (state == RR_S) begin
                    rsp_sum <= m1_axi.rdata;
                end else begin
                    rsp_stat <= m1_axi.rdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_adder_axi_sequencer.sv
// Randomized bench for the adder AXI sequencer with an adder slave model and a transaction-level reference.
// Latency: checks every cycle; expected AXI operations and responses are queued at each grant.
// Backpressure: slave ready/valid delays and rsp_ready stalls are randomized or forced per test.
module tb_adder_axi_sequencer;
    localparam int DW = 32;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [DW-1:0] req0_a, req0_b, req1_a, req1_b;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err, busy;
    logic [DW-1:0] rsp_sum, rsp_stat;

    adder_axi_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) m1_axi ();

    adder_axi_sequencer dut (
        .m1_axi_aclk   (clk),
        .m1_axi_areset (rst),
        .req0_valid    (req0_valid),
        .req0_ready    (req0_ready),
        .req0_a        (req0_a),
        .req0_b        (req0_b),
        .req1_valid    (req1_valid),
        .req1_ready    (req1_ready),
        .req1_a        (req1_a),
        .req1_b        (req1_b),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_sum       (rsp_sum),
        .rsp_stat      (rsp_stat),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .m1_axi        (m1_axi)
    );

    typedef struct { bit wr; logic [7:0] addr; logic [31:0] data; } axi_op_t;
    typedef struct { bit id; logic [31:0] sum; logic [31:0] stat; bit err; } rsp_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester and reference-model state
    bit          pend [2];
    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    bit          in_flight;
    bit          last_m;
    axi_op_t     exp_axi [$];
    rsp_t        exp_rsp [$];
    int          auto_left;
    int          cur_mode, next_mode;   // 0 ok, 1 bresp on A, 2 bresp on B, 3 rresp on sum, 4 rresp on stat
    int          rsp_wait, next_rsp_wait;

    // Slave model state
    logic [31:0] mem_a, mem_b, r_data;
    bit          b_pend, b_err, r_pend, r_err, aw_got, w_got, rand_dly;
    int          b_wait, r_wait, fixed_r_wait;
    int          aw_cnt, w_cnt, ar_cnt, aw_dly, w_dly, ar_dly;
    logic [7:0]  aw_addr_s;
    logic [31:0] w_data_s;

    // Protocol history and per-transaction counters
    bit          pv_aw_stall, pv_aw_hs, pv_w_stall, pv_w_hs, pv_ar_stall, pv_ar_hs;
    logic [7:0]  pv_awaddr, pv_araddr;
    logic [31:0] pv_wdata;
    int          aw_cyc, w_cyc, ar_cyc;
    logic [31:0] last_sum;
    bit          last_id, last_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] stat_of(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return 32'h0000_A500 | {31'd0, s[32]};
    endfunction

    function automatic int pick();
        if (rand_dly) return int'($urandom_range(0, 2));
        return 0;
    endfunction

    task automatic drive_idle();
        m1_axi.awready = 1'b0; m1_axi.wready = 1'b0; m1_axi.arready = 1'b0;
        m1_axi.bvalid  = 1'b0; m1_axi.bresp  = 1'b0;
        m1_axi.rvalid  = 1'b0; m1_axi.rresp  = 1'b0; m1_axi.rdata = '0;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    endtask

    task automatic clear_model();
        in_flight = 0; last_m = 1; exp_axi.delete(); exp_rsp.delete();
        pend[0] = 0; pend[1] = 0; b_pend = 0; r_pend = 0; aw_got = 0; w_got = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; aw_dly = 0; w_dly = 0; ar_dly = 0;
        pv_aw_stall = 0; pv_aw_hs = 0; pv_w_stall = 0; pv_w_hs = 0; pv_ar_stall = 0; pv_ar_hs = 0;
    endtask

    task automatic compare_op(input bit wr, input logic [7:0] addr, input logic [31:0] data);
        axi_op_t op;
        if (exp_axi.size() == 0) begin
            check("axi_unexpected_op", {wr, addr}, 9'h1FF);
        end else begin
            op = exp_axi.pop_front();
            check("axi_kind", wr, op.wr);
            check("axi_addr", addr, op.addr);
            if (wr) check("axi_wdata", data, op.data);
        end
    endtask

    task automatic grant_model(input bit g);
        logic [31:0] a, b;
        bit          err;
        a = op_a[g]; b = op_b[g];
        pend[g] = 0; in_flight = 1; last_m = g;
        cur_mode = (next_mode >= 0) ? next_mode :
                   (($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4)));
        rsp_wait = (next_rsp_wait >= 0) ? next_rsp_wait : int'($urandom_range(0, 3));
        aw_cyc = 0; w_cyc = 0; ar_cyc = 0;
        exp_axi.push_back('{1'b1, 8'd0, a});
        if (cur_mode != 1) exp_axi.push_back('{1'b1, 8'd4, b});
        if (cur_mode == 0 || cur_mode >= 3) exp_axi.push_back('{1'b0, 8'd24, 32'd0});
        if (cur_mode == 0 || cur_mode == 4) exp_axi.push_back('{1'b0, 8'd28, 32'd0});
        err = (cur_mode != 0);
        exp_rsp.push_back('{g, err ? 32'd0 : a + b, err ? 32'd0 : stat_of(a, b), err});
    endtask

    // One clock cycle: drive at the falling edge, then observe what the next rising edge will accept.
    task automatic step();
        bit e_any, g;
        rsp_t er;
        @(negedge clk);
        if (rst) begin
            drive_idle();
            return;
        end
        if (b_pend && b_wait > 0) begin m1_axi.bvalid = 1'b0; b_wait--; end
        else begin m1_axi.bvalid = b_pend; m1_axi.bresp = b_pend & b_err; end
        if (r_pend && r_wait > 0) begin m1_axi.rvalid = 1'b0; r_wait--; end
        else begin
            m1_axi.rvalid = r_pend; m1_axi.rresp = r_pend & r_err;
            m1_axi.rdata  = r_pend ? r_data : 32'd0;
        end
        m1_axi.awready = m1_axi.awvalid && (aw_cnt >= aw_dly);
        if (m1_axi.awvalid && !m1_axi.awready) aw_cnt++;
        m1_axi.wready = m1_axi.wvalid && (w_cnt >= w_dly);
        if (m1_axi.wvalid && !m1_axi.wready) w_cnt++;
        m1_axi.arready = m1_axi.arvalid && (ar_cnt >= ar_dly);
        if (m1_axi.arvalid && !m1_axi.arready) ar_cnt++;
        if (rsp_valid) begin
            if (rsp_wait > 0) begin rsp_ready = 1'b0; rsp_wait--; end
            else rsp_ready = 1'b1;
        end else begin
            rsp_ready = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 2; i++) begin
            if (auto_left > 0 && !pend[i] && $urandom_range(0, 3) == 0) begin
                pend[i] = 1; op_a[i] = $urandom; op_b[i] = $urandom; auto_left--;
            end
        end
        req0_valid = pend[0]; req0_a = op_a[0]; req0_b = op_b[0];
        req1_valid = pend[1]; req1_a = op_a[1]; req1_b = op_b[1];
        #1;
        check("busy", busy, in_flight);
        if (pv_aw_stall) begin check("aw_hold", m1_axi.awvalid, 1); check("aw_addr_stable", m1_axi.awaddr, pv_awaddr); end
        if (pv_aw_hs)    check("aw_drop", m1_axi.awvalid, 0);
        if (pv_w_stall)  begin check("w_hold", m1_axi.wvalid, 1); check("w_data_stable", m1_axi.wdata, pv_wdata); end
        if (pv_w_hs)     check("w_drop", m1_axi.wvalid, 0);
        if (pv_ar_stall) begin check("ar_hold", m1_axi.arvalid, 1); check("ar_addr_stable", m1_axi.araddr, pv_araddr); end
        if (pv_ar_hs)    check("ar_drop", m1_axi.arvalid, 0);
        if (m1_axi.awvalid) aw_cyc++;
        if (m1_axi.wvalid)  w_cyc++;
        if (m1_axi.arvalid) ar_cyc++;
        if (m1_axi.awvalid && m1_axi.awready) begin
            aw_got = 1; aw_addr_s = m1_axi.awaddr; aw_cnt = 0; aw_dly = pick();
        end
        if (m1_axi.wvalid && m1_axi.wready) begin
            check("wstrb", m1_axi.wstrb, 4'hF);
            w_got = 1; w_data_s = m1_axi.wdata; w_cnt = 0; w_dly = pick();
        end
        if (aw_got && w_got) begin
            aw_got = 0; w_got = 0;
            compare_op(1'b1, aw_addr_s, w_data_s);
            if (aw_addr_s == 8'd0) mem_a = w_data_s;
            if (aw_addr_s == 8'd4) mem_b = w_data_s;
            b_pend = 1; b_wait = pick();
            b_err = (cur_mode == 1 && aw_addr_s == 8'd0) || (cur_mode == 2 && aw_addr_s == 8'd4);
        end
        if (m1_axi.bvalid && m1_axi.bready) b_pend = 0;
        if (m1_axi.arvalid && m1_axi.arready) begin
            compare_op(1'b0, m1_axi.araddr, 32'd0);
            r_pend = 1;
            r_wait = (fixed_r_wait >= 0) ? fixed_r_wait : pick();
            r_data = (m1_axi.araddr == 8'd24) ? mem_a + mem_b :
                     (m1_axi.araddr == 8'd28) ? stat_of(mem_a, mem_b) : 32'hDEAD_BEEF;
            r_err  = (cur_mode == 3 && m1_axi.araddr == 8'd24) || (cur_mode == 4 && m1_axi.araddr == 8'd28);
            ar_cnt = 0; ar_dly = pick();
        end
        if (m1_axi.rvalid && m1_axi.rready) r_pend = 0;
        e_any = !in_flight && (pend[0] || pend[1]);
        g = (pend[0] && pend[1]) ? !last_m : pend[1];
        check("req0_ready", req0_ready, e_any && !g);
        check("req1_ready", req1_ready, e_any && g);
        if (e_any) grant_model(g);
        if (rsp_valid) begin
            if (exp_rsp.size() == 0) begin
                check("rsp_unexpected", rsp_valid, 0);
            end else begin
                er = exp_rsp[0];
                check("rsp_id", rsp_id, er.id);
                check("rsp_sum", rsp_sum, er.sum);
                check("rsp_stat", rsp_stat, er.stat);
                check("rsp_err", rsp_err, er.err);
                if (rsp_ready) begin
                    check("axi_ops_missing", exp_axi.size(), 0);
                    void'(exp_rsp.pop_front());
                    in_flight = 0;
                    last_sum = rsp_sum; last_id = rsp_id; last_err = rsp_err;
                end
            end
        end
        pv_aw_stall = m1_axi.awvalid && !m1_axi.awready; pv_aw_hs = m1_axi.awvalid && m1_axi.awready;
        pv_w_stall  = m1_axi.wvalid  && !m1_axi.wready;  pv_w_hs  = m1_axi.wvalid  && m1_axi.wready;
        pv_ar_stall = m1_axi.arvalid && !m1_axi.arready; pv_ar_hs = m1_axi.arvalid && m1_axi.arready;
        pv_awaddr = m1_axi.awaddr; pv_wdata = m1_axi.wdata; pv_araddr = m1_axi.araddr;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        int n = 0;
        while ((pend[0] || pend[1] || in_flight || auto_left > 0) && n < max_cyc) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, n < max_cyc, 1);
    endtask

    initial begin
        int n;
        clear_model();
        drive_idle();
        auto_left = 0; next_mode = 0; next_rsp_wait = 0; fixed_r_wait = -1; rand_dly = 0;
        mem_a = '0; mem_b = '0; r_data = '0; b_err = 0; r_err = 0; b_wait = 0; r_wait = 0;
        req0_valid = 1'b1;
        #2;
        check("rst_awvalid", m1_axi.awvalid, 0);
        check("rst_wvalid", m1_axi.wvalid, 0);
        check("rst_bready", m1_axi.bready, 0);
        check("rst_arvalid", m1_axi.arvalid, 0);
        check("rst_rready", m1_axi.rready, 0);
        check("rst_awaddr", m1_axi.awaddr, 0);
        check("rst_wdata", m1_axi.wdata, 0);
        check("rst_araddr", m1_axi.araddr, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_req1_ready", req1_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_id, rsp_err, rsp_sum, rsp_stat}, 0);
        check("rst_busy", busy, 0);
        repeat (2) @(negedge clk);
        req0_valid = 1'b0;
        rst = 1'b0;

        // Single request, zero-wait slave
        pend[0] = 1; op_a[0] = 32'd39; op_b[0] = 32'd40;
        wait_idle(200, "basic");
        check("basic_sum", last_sum, 32'd79);
        check("basic_id", last_id, 0);
        check("basic_err", last_err, 0);

        // Both requesters raised together, twice
        for (int r = 0; r < 2; r++) begin
            pend[0] = 1; op_a[0] = $urandom; op_b[0] = $urandom;
            pend[1] = 1; op_a[1] = $urandom; op_b[1] = $urandom;
            wait_idle(400, "both");
        end

        // Address channel stalled three cycles, data channel immediate
        aw_dly = 3; aw_cnt = 0;
        pend[0] = 1; op_a[0] = $urandom; op_b[0] = $urandom;
        wait_idle(200, "aw_stall");
        check("aw_stall_awvalid_cycles", aw_cyc, 5);
        check("aw_stall_wvalid_cycles", w_cyc, 2);

        // Error write response on operand A
        next_mode = 1;
        pend[1] = 1; op_a[1] = $urandom; op_b[1] = $urandom;
        wait_idle(200, "bresp_err");
        check("bresp_err_aw_cycles", aw_cyc, 1);
        check("bresp_err_ar_cycles", ar_cyc, 0);
        check("bresp_err_flag", last_err, 1);
        next_mode = 0;

        // Response stalled five cycles while req1 waits
        next_rsp_wait = 5;
        pend[0] = 1; op_a[0] = $urandom; op_b[0] = $urandom;
        n = 0;
        while (!in_flight && n < 50) begin step(); n++; end
        check("rsp_stall_granted", in_flight, 1);
        next_rsp_wait = 0;
        pend[1] = 1; op_a[1] = $urandom; op_b[1] = $urandom;
        wait_idle(300, "rsp_stall");

        // Reset while waiting for the sum read data
        fixed_r_wait = 4;
        pend[0] = 1; op_a[0] = $urandom; op_b[0] = $urandom;
        n = 0;
        while (!r_pend && n < 100) begin step(); n++; end
        check("rr_s_reached", r_pend, 1);
        step();
        check("rr_s_rready", m1_axi.rready, 1);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_rready", m1_axi.rready, 0);
        check("mid_rst_arvalid", m1_axi.arvalid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        clear_model();
        fixed_r_wait = -1;
        repeat (3) begin
            step();
            check("in_rst_rsp_valid", rsp_valid, 0);
        end
        rst = 1'b0;
        pend[0] = 1; op_a[0] = $urandom; op_b[0] = $urandom;
        pend[1] = 1; op_a[1] = $urandom; op_b[1] = $urandom;
        wait_idle(400, "post_rst");

        // Randomized traffic: operands, delays, error injection, response stalls
        rand_dly = 1; next_mode = -1; next_rsp_wait = -1; auto_left = 40;
        wait_idle(20000, "random");
        check("final_axi_queue", exp_axi.size(), 0);
        check("final_rsp_queue", exp_rsp.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
